// File: rtl/axi_cfg_slave.sv
// ---------------------------------------------------------------------------
// axi_cfg_slave
//   AXI4 responder for the host configuration port. Single-beat and burst
//   reads/writes land in a bank of N_REGS 32-bit registers, which are exported
//   to the accelerator core together with per-register write pulses.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   s_axi_aw* / w* / b*  AXI4 write address, write data, write response
//   s_axi_ar* / r*       AXI4 read address, read data
//   reg_q              register contents, reg i at [32*i +: 32]
//   reg_we             one-cycle pulse, bit i set when reg i was written on
//                      the previous edge
//
// Optional feature (macro AXI_CFG_SLVERR_EN)
//   Defined: out-of-range beats and wlast mismatches answer SLVERR.
//   Undefined: every response is OKAY and wlast is ignored.
// ---------------------------------------------------------------------------
module axi_cfg_slave #(
   parameter int unsigned                AXI_ID_WIDTH    = 6,
   parameter int unsigned                AXIL_WIDTH      = 32,
   parameter int unsigned                AXIL_ADDR_WIDTH = 40,
   parameter int unsigned                AXIL_STRB_WIDTH = AXIL_WIDTH / 8,
   parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR  = '0,
   parameter int unsigned                N_REGS          = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   // write address
   input  logic [AXI_ID_WIDTH-1:0]    s_axi_awid,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]                 s_axi_awlen,
   input  logic [2:0]                 s_axi_awsize,
   input  logic [1:0]                 s_axi_awburst,
   input  logic                       s_axi_awlock,
   input  logic [3:0]                 s_axi_awcache,
   input  logic [2:0]                 s_axi_awprot,
   input  logic                       s_axi_awvalid,
   output logic                       s_axi_awready,
   // write data
   input  logic [AXIL_WIDTH-1:0]      s_axi_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                       s_axi_wlast,
   input  logic                       s_axi_wvalid,
   output logic                       s_axi_wready,
   // write response
   output logic [AXI_ID_WIDTH-1:0]    s_axi_bid,
   output logic [1:0]                 s_axi_bresp,
   output logic                       s_axi_bvalid,
   input  logic                       s_axi_bready,
   // read address
   input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
   input  logic [AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]                 s_axi_arlen,
   input  logic [2:0]                 s_axi_arsize,
   input  logic [1:0]                 s_axi_arburst,
   input  logic                       s_axi_arlock,
   input  logic [3:0]                 s_axi_arcache,
   input  logic [2:0]                 s_axi_arprot,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,
   // read data
   output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
   output logic [AXIL_WIDTH-1:0]      s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rlast,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,
   // core side
   output logic [N_REGS*32-1:0]       reg_q,
   output logic [N_REGS-1:0]          reg_we
);

   localparam int unsigned AW   = AXIL_ADDR_WIDTH;
   localparam int unsigned IdxW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [AW-1:0] NRegsA = AW'(N_REGS);
   localparam logic [AW-1:0] Step   = AW'(4);
   localparam logic [1:0]    BurstFixed = 2'b00;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic       {RIdle, RData}        r_state_e;

   logic [31:0] regs_q [N_REGS];

   // ---------------- write channel state ----------------
   w_state_e                w_state_q, w_state_d;
   logic [AXI_ID_WIDTH-1:0] w_id_q;
   logic [AW-1:0]           w_addr_q;
   logic [7:0]              w_len_q, w_cnt_q;
   logic [1:0]              w_burst_q;
   logic                    w_err_q;
   logic                    awready_q, wready_q, bvalid_q;
   logic [N_REGS-1:0]       we_d, reg_we_q;

   logic                    aw_hs, w_hs, b_hs, w_final, w_in, w_beat_err;
   logic [AW-1:0]           w_off;
   logic [IdxW-1:0]         w_idx;

   // ---------------- read channel state ----------------
   r_state_e                r_state_q, r_state_d;
   logic [AXI_ID_WIDTH-1:0] r_id_q;
   logic [AW-1:0]           r_addr_q;
   logic [7:0]              r_len_q, r_cnt_q;
   logic [1:0]              r_burst_q;
   logic                    arready_q, rvalid_q, rlast_q;
   logic [31:0]             rdata_q;
   logic [1:0]              rresp_q;

   logic                    ar_hs, r_hs, r_final, r_load, r_in;
   logic [AW-1:0]           r_load_addr, r_off;
   logic [IdxW-1:0]         r_idx;
   logic [31:0]             rdata_d;

   assign aw_hs = s_axi_awvalid && awready_q;
   assign w_hs  = s_axi_wvalid && wready_q;
   assign b_hs  = bvalid_q && s_axi_bready;
   assign ar_hs = s_axi_arvalid && arready_q;
   assign r_hs  = rvalid_q && s_axi_rready;

   // ---------------- address decode ----------------
   assign w_off = w_addr_q - AXIL_BASE_ADDR;
   assign w_in  = (w_addr_q >= AXIL_BASE_ADDR) && ({2'b00, w_off[AW-1:2]} < NRegsA);
   assign w_idx = w_off[IdxW+1:2];

   // Beat 0 comes straight from the AR bus; later beats from the stepped address.
   assign r_load_addr = ar_hs ? s_axi_araddr :
                        (r_burst_q == BurstFixed) ? r_addr_q : r_addr_q + Step;
   assign r_off = r_load_addr - AXIL_BASE_ADDR;
   assign r_in  = (r_load_addr >= AXIL_BASE_ADDR) && ({2'b00, r_off[AW-1:2]} < NRegsA);
   assign r_idx = r_off[IdxW+1:2];

   // ---------------- write FSM ----------------
   assign w_final = (w_cnt_q == w_len_q);

`ifdef AXI_CFG_SLVERR_EN
   assign w_beat_err = !w_in || (s_axi_wlast != w_final);
`else
   assign w_beat_err = !w_in;
`endif

   always_comb begin
      w_state_d = w_state_q;
      unique case (w_state_q)
         WIdle:   if (aw_hs) w_state_d = WData;
         WData:   if (w_hs && w_final) w_state_d = WResp;
         WResp:   if (b_hs) w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      we_d = '0;
      for (int i = 0; i < N_REGS; i++) begin
         we_d[i] = w_hs && w_in && (w_idx == IdxW'(i));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= WIdle;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_burst_q <= '0;
         w_err_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         reg_we_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         // Readies/valids registered from next state so they stay low in reset.
         awready_q <= (w_state_d == WIdle);
         wready_q  <= (w_state_d == WData);
         bvalid_q  <= (w_state_d == WResp);
         reg_we_q  <= we_d;
         if (aw_hs) begin
            w_id_q    <= s_axi_awid;
            w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;
            w_burst_q <= s_axi_awburst;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
         end else if (w_hs) begin
            w_cnt_q <= w_cnt_q + 8'd1;
            // WRAP is stepped like INCR; the bank is never wrapped.
            if (w_burst_q != BurstFixed) w_addr_q <= w_addr_q + Step;
            if (w_beat_err) w_err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_REGS; i++) begin
            if (we_d[i]) begin
               for (int b = 0; b < 4; b++) begin
                  if (s_axi_wstrb[b]) regs_q[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   // ---------------- read FSM ----------------
   assign r_final = (r_cnt_q == r_len_q);
   assign r_load  = ar_hs || (r_hs && !r_final);
   // Sampled from regs_q before this edge's write lands: a colliding write
   // returns the old value.
   assign rdata_d = r_in ? regs_q[r_idx] : '0;

   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         RIdle:   if (ar_hs) r_state_d = RData;
         RData:   if (r_hs && r_final) r_state_d = RIdle;
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= RIdle;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_burst_q <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= (r_state_d == RIdle);
         rvalid_q  <= (r_state_d == RData);
         if (ar_hs) begin
            r_id_q    <= s_axi_arid;
            r_len_q   <= s_axi_arlen;
            r_burst_q <= s_axi_arburst;
            r_cnt_q   <= '0;
         end else if (r_hs && !r_final) begin
            r_cnt_q <= r_cnt_q + 8'd1;
         end
         if (r_load) begin
            r_addr_q <= r_load_addr;
            rdata_q  <= rdata_d;
            rlast_q  <= ar_hs ? (s_axi_arlen == 8'd0) : ((r_cnt_q + 8'd1) == r_len_q);
`ifdef AXI_CFG_SLVERR_EN
            rresp_q  <= r_in ? 2'b00 : 2'b10;
`else
            rresp_q  <= 2'b00;
`endif
         end
      end
   end

   // ---------------- outputs ----------------
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bid     = w_id_q;
`ifdef AXI_CFG_SLVERR_EN
   assign s_axi_bresp   = w_err_q ? 2'b10 : 2'b00;
`else
   assign s_axi_bresp   = 2'b00;
`endif
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rid     = r_id_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign reg_we        = reg_we_q;

   for (genvar g = 0; g < N_REGS; g++) begin : g_reg_out
      assign reg_q[32*g +: 32] = regs_q[g];
   end

   // Inputs the register bank has no use for.
   logic unused_inputs;
`ifdef AXI_CFG_SLVERR_EN
   assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                            s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                            w_off[1:0], r_off[1:0]};
`else
   assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                            s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                            w_off[1:0], r_off[1:0], s_axi_wlast, w_err_q};
`endif

endmodule

// File: tb/tb_axi_cfg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_cfg_slave
//   Self-checking bench for axi_cfg_slave: directed cases plus randomized
//   reads/writes compared against an array model of the register bank.
// ---------------------------------------------------------------------------
module tb_axi_cfg_slave;

   localparam int unsigned IW   = 6;
   localparam int unsigned AW   = 40;
   localparam int unsigned N    = 16;
   localparam logic [39:0] BASE = 40'h10_0000_1000;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [IW-1:0] awid = '0, arid = '0;
   logic [AW-1:0] awaddr = '0, araddr = '0;
   logic [7:0]    awlen = '0, arlen = '0;
   logic [2:0]    awsize = 3'd2, arsize = 3'd2;
   logic [1:0]    awburst = '0, arburst = '0;
   logic          awlock = 1'b0, arlock = 1'b0;
   logic [3:0]    awcache = '0, arcache = '0;
   logic [2:0]    awprot = '0, arprot = '0;
   logic          awvalid = 1'b0, arvalid = 1'b0;
   logic          awready, arready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wlast = 1'b0, wvalid = 1'b0, wready;
   logic [IW-1:0] bid, rid;
   logic [1:0]    bresp, rresp;
   logic          bvalid, bready = 1'b0;
   logic [31:0]   rdata;
   logic          rlast, rvalid, rready = 1'b0;
   logic [N*32-1:0] reg_q;
   logic [N-1:0]  reg_we;

   axi_cfg_slave #(
      .AXI_ID_WIDTH   (IW),
      .AXIL_ADDR_WIDTH(AW),
      .AXIL_BASE_ADDR (BASE),
      .N_REGS         (N)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(awlock),
      .s_axi_awcache(awcache), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(arlock),
      .s_axi_arcache(arcache), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_q(reg_q), .reg_we(reg_we)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mdl [N];
   logic [31:0] wbuf_d [16];
   logic [3:0]  wbuf_s [16];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Register index hit by a byte address, or -1 when outside the bank.
   function automatic int idx_of(input logic [39:0] a);
      if (a < BASE) return -1;
      if ((a - BASE) / 4 >= 40'(N)) return -1;
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [39:0] beat_addr(input logic [39:0] a, input logic [1:0] burst,
                                             input int b);
      return (burst == 2'b00) ? a : a + 40'(4 * b);
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < N; i++)
         check_eq($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q[32*i +: 32]), 64'(mdl[i]));
   endtask

   // Called at posedge+1; returns at posedge+1. Beat data comes from wbuf_d/wbuf_s.
   task automatic axi_write(input logic [39:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
      int            n;
      int            idx;
      logic          err;
      logic [N-1:0]  exp_we;
      logic [IW-1:0] id;
      id      = IW'($urandom);
      awid    = id;
      awaddr  = addr;
      awlen   = len;
      awburst = burst;
      awvalid = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (awready) break;
         if (++n > 50) begin
            check_eq("aw_timeout", 64'(awready), 64'(1));
            awvalid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      err = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata  = wbuf_d[b];
         wstrb  = wbuf_s[b];
         wlast  = (b == int'(len));
         wvalid = 1'b1;
         n = 0;
         while (1) begin
            @(negedge clk);
            if (wready) break;
            if (++n > 50) begin
               check_eq("w_timeout", 64'(wready), 64'(1));
               wvalid = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
         idx    = idx_of(beat_addr(addr, burst, b));
         exp_we = '0;
         if (idx >= 0) begin
            exp_we[idx] = 1'b1;
            for (int k = 0; k < 4; k++)
               if (wbuf_s[b][k]) mdl[idx][8*k +: 8] = wbuf_d[b][8*k +: 8];
         end else begin
            err = 1'b1;
         end
         check_eq($sformatf("reg_we beat%0d", b), 64'(reg_we), 64'(exp_we));
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      check_regs("wr");
      @(posedge clk); #1;
      check_eq("reg_we_idle", 64'(reg_we), 64'(0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      bready = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bvalid) break;
         if (++n > 50) begin
            check_eq("b_timeout", 64'(bvalid), 64'(1));
            bready = 1'b0;
            return;
         end
      end
      check_eq("bid", 64'(bid), 64'(id));
`ifdef AXI_CFG_SLVERR_EN
      check_eq("bresp", 64'(bresp), err ? 64'(2) : 64'(0));
`else
      check_eq("bresp", 64'(bresp), 64'(0));
`endif
      @(posedge clk); #1;
      bready = 1'b0;
      check_eq("bvalid_drop", 64'(bvalid), 64'(0));
   endtask

   // Called at posedge+1; returns at posedge+1. rready toggles randomly.
   task automatic axi_read(input logic [39:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
      int            n;
      int            b;
      int            idx;
      logic [IW-1:0] id;
      logic          held;
      logic [31:0]   held_data;
      id      = IW'($urandom);
      arid    = id;
      araddr  = addr;
      arlen   = len;
      arburst = burst;
      arvalid = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (arready) break;
         if (++n > 50) begin
            check_eq("ar_timeout", 64'(arready), 64'(1));
            arvalid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      b = 0;
      n = 0;
      held = 1'b0;
      held_data = '0;
      while (b <= int'(len)) begin
         @(negedge clk);
         if (held && rvalid) check_eq("r_hold", 64'(rdata), 64'(held_data));
         rready = 1'($urandom);
         held = 1'b0;
         if (rvalid && rready) begin
            idx = idx_of(beat_addr(addr, burst, b));
            check_eq($sformatf("rdata beat%0d", b), 64'(rdata),
                     (idx >= 0) ? 64'(mdl[idx]) : 64'(0));
            check_eq($sformatf("rlast beat%0d", b), 64'(rlast), 64'(b == int'(len)));
            check_eq("rid", 64'(rid), 64'(id));
`ifdef AXI_CFG_SLVERR_EN
            check_eq("rresp", 64'(rresp), (idx >= 0) ? 64'(0) : 64'(2));
`else
            check_eq("rresp", 64'(rresp), 64'(0));
`endif
            b++;
         end else if (rvalid) begin
            held      = 1'b1;
            held_data = rdata;
         end
         if (++n > 300) begin
            check_eq("r_timeout", 64'(b), 64'(int'(len) + 1));
            rready = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      rready = 1'b0;
      check_eq("rvalid_drop", 64'(rvalid), 64'(0));
   endtask

   initial begin
      int          k;
      logic [39:0] a;
      logic [7:0]  len;
      logic [1:0]  burst;
      for (int i = 0; i < N; i++) mdl[i] = '0;

      // Reset state
      #1;
      check_eq("rst reg_q", 64'(|reg_q), 64'(0));
      check_eq("rst reg_we", 64'(reg_we), 64'(0));
      check_eq("rst awready", 64'(awready), 64'(0));
      check_eq("rst arready", 64'(arready), 64'(0));
      check_eq("rst bvalid", 64'(bvalid), 64'(0));
      check_eq("rst rvalid", 64'(rvalid), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      check_eq("awready after rst", 64'(awready), 64'(1));
      check_eq("arready after rst", 64'(arready), 64'(1));

      // Single full write to reg 2
      wbuf_d[0] = 32'hDEADBEEF; wbuf_s[0] = 4'hF;
      axi_write(BASE + 40'd8, 8'd0, 2'b01);
      check_eq("reg2 full", 64'(reg_q[64 +: 32]), 64'(32'hDEADBEEF));

      // Strobed write over it
      wbuf_d[0] = 32'h1234ABCD; wbuf_s[0] = 4'h3;
      axi_write(BASE + 40'd8, 8'd0, 2'b01);
      check_eq("reg2 strobed", 64'(reg_q[64 +: 32]), 64'(32'hDEADABCD));

      // INCR write of 4 beats then INCR read back
      for (int i = 0; i < 4; i++) begin
         wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF;
      end
      axi_write(BASE, 8'd3, 2'b01);
      axi_read(BASE, 8'd3, 2'b01);

      // FIXED burst to reg 1: two pulses, last value wins
      wbuf_d[0] = 32'd1; wbuf_s[0] = 4'hF;
      wbuf_d[1] = 32'd2; wbuf_s[1] = 4'hF;
      axi_write(BASE + 40'd4, 8'd1, 2'b00);
      check_eq("reg1 fixed", 64'(reg_q[32 +: 32]), 64'(2));

      // Out-of-range read just past the bank
      axi_read(BASE + 40'(4 * N), 8'd0, 2'b01);

      // Randomized traffic, some beats below/above the bank
      for (int t = 0; t < 30; t++) begin
         k     = $urandom_range(0, N + 3);
         a     = BASE - 40'd8 + 40'(4 * k) + 40'($urandom_range(0, 3));
         len   = 8'($urandom_range(0, 3));
         burst = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 4; i++) begin
               wbuf_d[i] = $urandom; wbuf_s[i] = 4'($urandom);
            end
            axi_write(a, len, burst);
         end else begin
            axi_read(a, len, burst);
         end
      end

      // Reset in the middle of a 4-beat write (during beat 1)
      awid = 6'h2A; awaddr = BASE; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
      k = 0;
      while (!awready && k < 50) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      awvalid = 1'b0;
      wdata = 32'hCAFE0000; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk); #1;
      wdata = 32'hCAFE0001;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      wvalid = 1'b0;
      for (int i = 0; i < N; i++) mdl[i] = '0;
      check_regs("midrst");
      check_eq("midrst bvalid", 64'(bvalid), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst awready", 64'(awready), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      check_eq("midrst no b", 64'(bvalid), 64'(0));

      // Bank still usable after the abandoned burst
      wbuf_d[0] = 32'h0BADF00D; wbuf_s[0] = 4'hF;
      axi_write(BASE + 40'd60, 8'd0, 2'b01);
      axi_read(BASE + 40'd52, 8'd2, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
